// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a dual-port word array: independent write (AW/W/B) and read (AR/R) FSMs.
// Optional build macro AXI_MEM_RESP_STALL_EN adds LFSR-driven ready/valid stalls.
module axi_mem_responder #(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned MemDepth     = 1024,
  parameter logic [AxiAddrWidth-1:0] BaseAddr = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AxiIdWidth-1:0]     aw_id_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AxiIdWidth-1:0]     b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AxiIdWidth-1:0]     ar_id_i,
  input  logic [AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiIdWidth-1:0]     r_id_o,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic [1:0]                dbg_wstate_o,
  output logic                      dbg_rstate_o
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid && ready;
  // a valid, once raised, stays high with stable payload until that transfer.

  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MemDepth);
  localparam int unsigned ExtW  = AxiAddrWidth + 12;
  localparam logic [2:0]      SizeMax = 3'(OffW);
  localparam logic [ExtW-1:0] MemLo   = ExtW'(BaseAddr);
  localparam logic [ExtW-1:0] MemHi   = MemLo + ExtW'(MemDepth * StrbW);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Start and last-beat addresses are compared in a widened space so an end past 4 GiB cannot wrap.
  function automatic logic burst_err(input logic [AxiAddrWidth-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [ExtW-1:0] v_start;
    logic [ExtW-1:0] v_last;
    logic [ExtW:0]   v_diff;
    v_start = ExtW'(addr);
    v_last  = (burst == BURST_INCR) ? v_start + (ExtW'(len) << size) : v_start;
    v_diff  = {1'b0, v_start} - {1'b0, MemLo};
    return (size > SizeMax) || burst[1] || v_diff[ExtW] || (v_last >= MemHi);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [AxiAddrWidth-1:0] addr);
    logic [AxiAddrWidth-1:0] v_off;
    v_off = addr - BaseAddr;
    return IdxW'(v_off >> OffW);
  endfunction

  function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] addr,
                                                        input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + (AxiAddrWidth'(1) << size) : addr;
  endfunction

  logic w_stall;
  logic w_rvalid;

  logic [0:0] r_rstate;

`ifdef AXI_MEM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_rpres;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Once a beat has been shown it is held until taken, regardless of the stall bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rpres <= 1'b0;
    end else begin
      r_rpres <= w_rvalid && !r_ready_i;
    end
  end

  assign w_stall  = r_lfsr[0];
  assign w_rvalid = (r_rstate == R_DATA) && (r_rpres || !w_stall);
`else
  assign w_stall  = 1'b0;
  assign w_rvalid = (r_rstate == R_DATA);
`endif

  logic [AxiDataWidth-1:0] r_mem [MemDepth];
  logic [AxiDataWidth-1:0] r_rdata;

  // Write channel state.
  logic [1:0]              r_wstate;
  logic [AxiIdWidth-1:0]   r_wid;
  logic [AxiAddrWidth-1:0] r_waddr;
  logic [7:0]              r_wlen;
  logic [7:0]              r_wcnt;
  logic [2:0]              r_wsize;
  logic [1:0]              r_wburst;
  logic                    r_werr;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;

  assign aw_ready_o = (r_wstate == W_IDLE) && !w_stall;
  assign w_ready_o  = (r_wstate == W_DATA) && !w_stall;
  assign b_valid_o  = (r_wstate == W_RESP);
  assign b_id_o     = r_wid;
  assign b_resp_o   = (b_valid_o && r_werr) ? RESP_SLVERR : RESP_OKAY;

  assign w_aw_hs = aw_valid_i && aw_ready_o;
  assign w_w_hs  = w_valid_i && w_ready_o;
  assign w_b_hs  = b_valid_o && b_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wid    <= aw_id_i;
            r_waddr  <= aw_addr_i;
            r_wlen   <= aw_len_i;
            r_wsize  <= aw_size_i;
            r_wburst <= aw_burst_i;
            r_werr   <= burst_err(aw_addr_i, aw_len_i, aw_size_i, aw_burst_i);
            r_wcnt   <= '0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
            // The beat count, not w_last_i, decides where the burst ends.
            if (r_wcnt == r_wlen) begin
              if (!w_last_i) r_werr <= 1'b1;
              r_wstate <= W_RESP;
            end else if (w_last_i) begin
              r_werr <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel state.
  logic [AxiIdWidth-1:0]   r_rid;
  logic [AxiAddrWidth-1:0] r_raddr;
  logic [7:0]              r_rlen;
  logic [7:0]              r_rcnt;
  logic [2:0]              r_rsize;
  logic [1:0]              r_rburst;
  logic                    r_rerr;

  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic [AxiAddrWidth-1:0] w_raddr_nxt;

  assign ar_ready_o  = (r_rstate == R_IDLE) && !w_stall;
  assign r_valid_o   = w_rvalid;
  assign r_id_o      = r_rid;
  assign r_data_o    = (w_rvalid && !r_rerr) ? r_rdata : '0;
  assign r_resp_o    = (w_rvalid && r_rerr) ? RESP_SLVERR : RESP_OKAY;
  assign r_last_o    = w_rvalid && (r_rcnt == r_rlen);

  assign w_ar_hs     = ar_valid_i && ar_ready_o;
  assign w_r_hs      = w_rvalid && r_ready_i;
  assign w_raddr_nxt = next_addr(r_raddr, r_rsize, r_rburst);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rerr   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rid    <= ar_id_i;
            r_raddr  <= ar_addr_i;
            r_rlen   <= ar_len_i;
            r_rsize  <= ar_size_i;
            r_rburst <= ar_burst_i;
            r_rerr   <= burst_err(ar_addr_i, ar_len_i, ar_size_i, ar_burst_i);
            r_rcnt   <= '0;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rcnt == r_rlen) begin
              r_rstate <= R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 8'd1;
              r_raddr <= w_raddr_nxt;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Array ports: the registered read samples the pre-write contents when both hit one word.
  logic                w_mem_we;
  logic [IdxW-1:0]     w_widx;
  logic                w_rd_en;
  logic [IdxW-1:0]     w_rd_idx;

  assign w_mem_we = w_w_hs && !r_werr;
  assign w_widx   = word_idx(r_waddr);
  assign w_rd_en  = w_ar_hs || w_r_hs;
  assign w_rd_idx = w_ar_hs ? word_idx(ar_addr_i) : word_idx(w_raddr_nxt);

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (w_strb_i[b]) r_mem[w_widx][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rd_en) r_rdata <= r_mem[w_rd_idx];
  end

  assign dbg_wstate_o = r_wstate;
  assign dbg_rstate_o = r_rstate;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed scenarios plus random bursts against a byte-level memory model.
module tb_axi_mem_responder;

  localparam int DW    = 128;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1024;
  localparam int BW    = DW + 2 + 1 + 4;
  localparam int TMO   = 500;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           aw_valid_i, aw_ready_o;
  logic [3:0]     aw_id_i;
  logic [31:0]    aw_addr_i;
  logic [7:0]     aw_len_i;
  logic [2:0]     aw_size_i;
  logic [1:0]     aw_burst_i;
  logic           w_valid_i, w_ready_o;
  logic [DW-1:0]  w_data_i;
  logic [NB-1:0]  w_strb_i;
  logic           w_last_i;
  logic           b_valid_o, b_ready_i;
  logic [3:0]     b_id_o;
  logic [1:0]     b_resp_o;
  logic           ar_valid_i, ar_ready_o;
  logic [3:0]     ar_id_i;
  logic [31:0]    ar_addr_i;
  logic [7:0]     ar_len_i;
  logic [2:0]     ar_size_i;
  logic [1:0]     ar_burst_i;
  logic           r_valid_o, r_ready_i;
  logic [3:0]     r_id_o;
  logic [DW-1:0]  r_data_o;
  logic [1:0]     r_resp_o;
  logic           r_last_o;
  logic [1:0]     dbg_wstate_o;
  logic           dbg_rstate_o;

  axi_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .dbg_wstate_o(dbg_wstate_o), .dbg_rstate_o(dbg_rstate_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model and scoreboard
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] wd_q [$];
  logic [NB-1:0] ws_q [$];
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] got_q [$];

  int rd_first_lat, rd_gaps, rd_stab_bad, b_early;

  function automatic longint beat_addr(input logic [31:0] addr, input logic [2:0] size,
                                       input logic [1:0] burst, input int i);
    if (burst == 2'b01) return longint'(addr) + longint'(i) * (longint'(1) << size);
    return longint'(addr);
  endfunction

  function automatic bit mdl_err(input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd4) || (burst == 2'b10) || (burst == 2'b11) ||
           (beat_addr(addr, size, burst, int'(len)) >= longint'(DEPTH * NB));
  endfunction

  task automatic mdl_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    if (!mdl_err(addr, len, size, burst)) begin
      for (int i = 0; i <= int'(len); i++) begin
        int w;
        w = int'(beat_addr(addr, size, burst, i) / NB);
        for (int b = 0; b < NB; b++)
          if (ws_q[i][b]) mdl_mem[w][b*8 +: 8] = wd_q[i][b*8 +: 8];
      end
    end
  endtask

  task automatic mdl_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit e;
    e = mdl_err(addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      logic [DW-1:0] d;
      int w;
      w = int'((beat_addr(addr, size, burst, i) / NB) % DEPTH);
      d = e ? '0 : mdl_mem[w];
      exp_q.push_back({d, (e ? 2'b10 : 2'b00), (i == int'(len)), id});
    end
  endtask

  // Driver tasks
  task automatic drive_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int last_at,
                             output logic [1:0] resp, output logic [3:0] bid, output int blat);
    int n;
    b_early = 0;
    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
    aw_size_i = size; aw_burst_i = burst;
    n = 0;
    while (!aw_ready_o && n < TMO) begin @(posedge clk_i); #1; n++; end
    if (n >= TMO) begin n_checks++; $display("FAIL aw_timeout: aw_ready_o never rose"); end
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid_i = 1'b1; w_data_i = wd_q[i]; w_strb_i = ws_q[i]; w_last_i = (i == last_at);
      n = 0;
      while (!w_ready_o && n < TMO) begin @(posedge clk_i); #1; n++; end
      if (n >= TMO) begin n_checks++; $display("FAIL w_timeout: beat %0d never accepted", i); end
      if (b_valid_o) b_early++;
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    blat = 0;
    while (!b_valid_o && blat < TMO) begin @(posedge clk_i); #1; blat++; end
    resp = b_resp_o; bid = b_id_o;
    b_ready_i = 1'b1;
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
    ar_size_i = size; ar_burst_i = burst;
    n = 0;
    while (!ar_ready_o && n < TMO) begin @(posedge clk_i); #1; n++; end
    if (n >= TMO) begin n_checks++; $display("FAIL ar_timeout: ar_ready_o never rose"); end
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic drive_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
    int cyc, beats;
    bit have_hold;
    logic rdy;
    logic [BW-1:0] hold, cur;
    got_q.delete();
    rd_first_lat = -1; rd_gaps = 0; rd_stab_bad = 0;
    drive_ar(id, addr, len, size, burst);
    cyc = 0; beats = 0; have_hold = 0; hold = '0;
    while (beats <= int'(len) && cyc < 4000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      r_ready_i = rdy;
      cur = {r_data_o, r_resp_o, r_last_o, r_id_o};
      if (r_valid_o) begin
        if (rd_first_lat < 0) rd_first_lat = cyc;
        if (have_hold && cur !== hold) rd_stab_bad++;
        if (rdy) begin got_q.push_back(cur); beats++; have_hold = 0; end
        else begin hold = cur; have_hold = 1; end
      end else begin
        if (have_hold) rd_stab_bad++;
        if (rd_first_lat >= 0) rd_gaps++;
        have_hold = 0;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    r_ready_i = 1'b0;
    if (cyc >= 4000) begin n_checks++; $display("FAIL r_timeout: got %0d of %0d beats", beats, int'(len) + 1); end
  endtask

  task automatic fill_wdata(input int nbeats, input logic [NB-1:0] strb);
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < nbeats; i++) begin
      wd_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      ws_q.push_back(strb);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst_i = 1'b0;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
    w_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    r_ready_i = 0;
    #2 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (aw_ready_o !== 1'b1) $display("FAIL reset_aw_ready: got %b want 1", aw_ready_o); else n_pass++;
    n_checks++; if (ar_ready_o !== 1'b1) $display("FAIL reset_ar_ready: got %b want 1", ar_ready_o); else n_pass++;
    n_checks++; if (w_ready_o !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", w_ready_o); else n_pass++;
    n_checks++; if ({b_valid_o, b_id_o, b_resp_o} !== 7'd0)
      $display("FAIL reset_b: got %h want 0", {b_valid_o, b_id_o, b_resp_o}); else n_pass++;
    n_checks++; if ({r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o} !== '0)
      $display("FAIL reset_r: got %h want 0", {r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o}); else n_pass++;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_preload();
    logic [1:0] resp; logic [3:0] bid; int blat;
    for (int k = 0; k < 4; k++) begin
      fill_wdata(256, '1);
      drive_write(4'(k), 32'(k * 256 * NB), 8'd255, 3'd4, 2'b01, 255, resp, bid, blat);
      mdl_write(32'(k * 256 * NB), 8'd255, 3'd4, 2'b01);
      n_checks++; if ({resp, bid} !== {2'b00, 4'(k)})
        $display("FAIL preload_b%0d: got resp=%b id=%h want resp=00 id=%h", k, resp, bid, 4'(k)); else n_pass++;
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic [3:0] bid; int blat;
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 4; i++) begin wd_q.push_back(DW'(8'hA0 + i)); ws_q.push_back('1); end
    drive_write(4'h5, 32'h40, 8'd3, 3'd4, 2'b01, 3, resp, bid, blat);
    mdl_write(32'h40, 8'd3, 3'd4, 2'b01);
    n_checks++; if ({resp, bid} !== {2'b00, 4'h5})
      $display("FAIL incr_b: got resp=%b id=%h want resp=00 id=5", resp, bid); else n_pass++;
    n_checks++; if (blat !== 0) $display("FAIL incr_b_latency: got %0d extra cycles want 0", blat); else n_pass++;
    n_checks++; if (aw_ready_o !== 1'b1) $display("FAIL incr_aw_ready_after_b: got %b want 1", aw_ready_o); else n_pass++;
    exp_q.delete();
    mdl_read(4'h9, 32'h40, 8'd3, 3'd4, 2'b01);
    drive_read(4'h9, 32'h40, 8'd3, 3'd4, 2'b01, 0);
    n_checks++; if (rd_first_lat !== 0) $display("FAIL incr_r_latency: got %0d want 0", rd_first_lat); else n_pass++;
    n_checks++; if (rd_gaps !== 0) $display("FAIL incr_r_gaps: got %0d want 0", rd_gaps); else n_pass++;
    n_checks++; if (got_q.size() !== 4) $display("FAIL incr_r_count: got %0d want 4", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      logic [BW-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL incr_r_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
    n_checks++; if (got_q[0][BW-1 -: DW] !== DW'(8'hA0)) $display("FAIL incr_r_first_data: got %h want a0", got_q[0][BW-1 -: DW]); else n_pass++;
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] bid; int blat;
    wd_q.delete(); ws_q.delete();
    wd_q.push_back('1); ws_q.push_back('1);
    drive_write(4'h1, 32'h0, 8'd0, 3'd4, 2'b01, 0, resp, bid, blat);
    mdl_write(32'h0, 8'd0, 3'd4, 2'b01);
    wd_q.delete(); ws_q.delete();
    wd_q.push_back('0); ws_q.push_back(NB'(1));
    drive_write(4'h2, 32'h0, 8'd0, 3'd4, 2'b01, 0, resp, bid, blat);
    mdl_write(32'h0, 8'd0, 3'd4, 2'b01);
    exp_q.delete();
    mdl_read(4'h3, 32'h0, 8'd0, 3'd4, 2'b01);
    drive_read(4'h3, 32'h0, 8'd0, 3'd4, 2'b01, 0);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0])
      $display("FAIL strobe_beat: got %h want %h", (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); else n_pass++;
    n_checks++; if (got_q.size() < 1 || got_q[0][BW-1 -: DW] !== {{(DW-8){1'b1}}, 8'h00})
      $display("FAIL strobe_data: got %h want ff..ff00", (got_q.size() > 0) ? got_q[0][BW-1 -: DW] : '0); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_r_backpressure();
    exp_q.delete();
    mdl_read(4'hC, 32'h80, 8'd7, 3'd4, 2'b01);
    drive_read(4'hC, 32'h80, 8'd7, 3'd4, 2'b01, 1);
    n_checks++; if (got_q.size() !== 8) $display("FAIL bp_count: got %0d want 8", got_q.size()); else n_pass++;
    n_checks++; if (rd_stab_bad !== 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", rd_stab_bad); else n_pass++;
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      logic [BW-1:0] e;
      e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] bid; int blat;
    fill_wdata(4, '1);
    drive_write(4'h7, 32'h100, 8'd3, 3'd4, 2'b10, 3, resp, bid, blat);
    mdl_write(32'h100, 8'd3, 3'd4, 2'b10);
    n_checks++; if (resp !== 2'b10) $display("FAIL err_wrap_b: got %b want 10", resp); else n_pass++;
    fill_wdata(4, '1);
    drive_write(4'h8, 32'(DEPTH * NB - 32), 8'd3, 3'd4, 2'b01, 3, resp, bid, blat);
    mdl_write(32'(DEPTH * NB - 32), 8'd3, 3'd4, 2'b01);
    n_checks++; if (resp !== 2'b10) $display("FAIL err_range_b: got %b want 10", resp); else n_pass++;
    exp_q.delete();
    mdl_read(4'h4, 32'h100, 8'd3, 3'd4, 2'b01);
    mdl_read(4'h4, 32'(DEPTH * NB - 32), 8'd1, 3'd4, 2'b01);
    mdl_read(4'h6, 32'(DEPTH * NB), 8'd3, 3'd4, 2'b01);
    mdl_read(4'hE, 32'h0, 8'd1, 3'd5, 2'b01);
    drive_read(4'h4, 32'h100, 8'd3, 3'd4, 2'b01, 0);
    for (int i = 0; i < got_q.size(); i++) begin
      logic [BW-1:0] e; e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL err_unchanged_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
    drive_read(4'h4, 32'(DEPTH * NB - 32), 8'd1, 3'd4, 2'b01, 0);
    for (int i = 0; i < got_q.size(); i++) begin
      logic [BW-1:0] e; e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL err_top_unchanged_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
    drive_read(4'h6, 32'(DEPTH * NB), 8'd3, 3'd4, 2'b01, 2);
    n_checks++; if (got_q.size() !== 4) $display("FAIL err_range_r_count: got %0d want 4", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      logic [BW-1:0] e; e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL err_range_r_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
    drive_read(4'hE, 32'h0, 8'd1, 3'd5, 2'b01, 0);
    for (int i = 0; i < got_q.size(); i++) begin
      logic [BW-1:0] e; e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL err_size_r_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
  endtask

  task automatic test_early_last();
    logic [1:0] resp; logic [3:0] bid; int blat;
    fill_wdata(3, '1);
    drive_write(4'hA, 32'h300, 8'd2, 3'd4, 2'b01, 1, resp, bid, blat);
    n_checks++; if (resp !== 2'b10) $display("FAIL early_last_b: got %b want 10", resp); else n_pass++;
    n_checks++; if (b_early !== 0) $display("FAIL early_last_b_early: b_valid seen %0d times before beat 2", b_early); else n_pass++;
    n_checks++; if (blat !== 0) $display("FAIL early_last_b_latency: got %0d want 0", blat); else n_pass++;
    // Re-establish known contents so later reads of this region do not depend on the aborted burst.
    fill_wdata(3, '1);
    drive_write(4'hA, 32'h300, 8'd2, 3'd4, 2'b01, 2, resp, bid, blat);
    mdl_write(32'h300, 8'd2, 3'd4, 2'b01);
    n_checks++; if (resp !== 2'b00) $display("FAIL early_last_rewrite_b: got %b want 00", resp); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    drive_ar(4'hD, 32'h200, 8'd7, 3'd4, 2'b01);
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    n_checks++; if (r_valid_o !== 1'b1) $display("FAIL rstmid_beat2_valid: got %b want 1", r_valid_o); else n_pass++;
    r_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    n_checks++; if (r_valid_o !== 1'b0) $display("FAIL rstmid_r_valid: got %b want 0", r_valid_o); else n_pass++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if ({ar_ready_o, r_valid_o, b_valid_o} !== 3'b100)
      $display("FAIL rstmid_after: got ar_ready,r_valid,b_valid=%b want 100", {ar_ready_o, r_valid_o, b_valid_o}); else n_pass++;
    exp_q.delete();
    mdl_read(4'h2, 32'h200, 8'd7, 3'd4, 2'b01);
    drive_read(4'h2, 32'h200, 8'd7, 3'd4, 2'b01, 0);
    n_checks++; if (got_q.size() !== 8) $display("FAIL rstmid_next_count: got %0d want 8", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      logic [BW-1:0] e; e = exp_q.pop_front();
      n_checks++; if (got_q[i] !== e) $display("FAIL rstmid_next_beat%0d: got %h want %h", i, got_q[i], e); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, exp_resp; logic [3:0] bid, id; int blat;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    int sel;
    for (int t = 0; t < 24; t++) begin
      for (int dir = 0; dir < 2; dir++) begin
        id   = 4'($urandom_range(0, 15));
        len  = 8'($urandom_range(0, 15));
        size = 3'($urandom_range(0, 5));
        sel  = $urandom_range(0, 9);
        burst = (sel == 0) ? 2'b10 : (sel == 1) ? 2'b11 : (sel < 4) ? 2'b00 : 2'b01;
        addr = 32'($urandom_range(0, DEPTH * NB - 1));
        if (dir == 0) begin
          wd_q.delete(); ws_q.delete();
          for (int i = 0; i <= int'(len); i++) begin
            wd_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            ws_q.push_back(NB'($urandom()));
          end
          exp_resp = mdl_err(addr, len, size, burst) ? 2'b10 : 2'b00;
          drive_write(id, addr, len, size, burst, int'(len), resp, bid, blat);
          mdl_write(addr, len, size, burst);
          n_checks++; if ({resp, bid, blat == 0} !== {exp_resp, id, 1'b1})
            $display("FAIL rand_b%0d: got resp=%b id=%h lat=%0d want resp=%b id=%h lat=0", t, resp, bid, blat, exp_resp, id); else n_pass++;
        end else begin
          exp_q.delete();
          mdl_read(id, addr, len, size, burst);
          drive_read(id, addr, len, size, burst, (t % 2 == 0) ? 0 : 2);
          n_checks++; if ({got_q.size() == int'(len) + 1, rd_stab_bad == 0, rd_gaps == 0} !== 3'b111)
            $display("FAIL rand_r%0d_shape: count=%0d want %0d unstable=%0d gaps=%0d", t, got_q.size(), int'(len) + 1, rd_stab_bad, rd_gaps); else n_pass++;
          for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            logic [BW-1:0] e; e = exp_q.pop_front();
            n_checks++; if (got_q[i] !== e) $display("FAIL rand_r%0d_beat%0d: got %h want %h", t, i, got_q[i], e); else n_pass++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_incr_burst();
    test_strobe();
    test_r_backpressure();
    test_errors();
    test_early_last();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
